// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, funct3 encodings,
// trap causes, write masks and the FSM state type.
package csr_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrInstreth  = 12'hC82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam logic [2:0] F3Priv = 3'b000;
  localparam logic [2:0] F3Rw   = 3'b001;
  localparam logic [2:0] F3Rs   = 3'b010;
  localparam logic [2:0] F3Rc   = 3'b011;
  localparam logic [2:0] F3Rwi  = 3'b101;
  localparam logic [2:0] F3Rsi  = 3'b110;
  localparam logic [2:0] F3Rci  = 3'b111;

  localparam logic [31:0] CauseIllegal = 32'd2;
  localparam logic [31:0] CauseBreak   = 32'd3;
  localparam logic [31:0] CauseEcall   = 32'd11;

  localparam logic [31:0] MstatusWmask = 32'h0000_0088;
  localparam logic [31:0] MieWmask     = 32'h0000_0888;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter; a write to either half overrides that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (wr_lo) begin
      q <= {q[63:32], wdata};
    end else if (wr_hi) begin
      q <= {wdata, q[31:0]};
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR execution unit: CSRRx read-modify-write, counters, ECALL/EBREAK/illegal
// traps. Three-state FSM, one op per three cycles, done two cycles after acceptance.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned HART_ID     = 0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] pc,
  input  logic        instret_inc,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        trap,
  output logic [31:0] trap_pc
);

  state_e      state_q;
  logic [31:0] instr_q, rs1_q, pc_q, old_q, cause_q, tval_q;
  logic        wen_q;
  logic        mie_bit_q, mpie_bit_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;

  logic [11:0] csr_addr;
  logic [2:0]  f3;
  logic [4:0]  uimm;
  logic [31:0] src, rdata, new_val, mstatus_rd, mstatus_wr;
  logic        known, is_csr_op, wr_attempt, is_ecall, is_ebreak, illegal, take_trap, commit;

  assign csr_addr   = instr_q[31:20];
  assign f3         = instr_q[14:12];
  assign uimm       = instr_q[19:15];
  assign rd_sel     = instr_q[11:7];
  assign src        = f3[2] ? {27'b0, uimm} : rs1_q;
  assign is_csr_op  = (f3 != F3Priv) && (f3 != 3'b100);
  // Set/clear with a zero operand field is a pure read and never counts as a write.
  assign wr_attempt = is_csr_op && (f3[1:0] == 2'b01 || uimm != 5'd0);
  assign is_ecall   = (instr_q == InstrEcall);
  assign is_ebreak  = (instr_q == InstrEbreak);
  assign illegal    = is_csr_op ? (!known || (wr_attempt && csr_addr[11:10] == 2'b11))
                                : !(is_ecall || is_ebreak);
  assign take_trap  = illegal || is_ecall || is_ebreak;
  assign commit     = (state_q == WRITE) && wen_q;
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_bit_q, 3'b0, mie_bit_q, 3'b0};
  assign mstatus_wr = new_val & MstatusWmask;

  always_comb begin
    rdata = '0;
    known = 1'b1;
    case (csr_addr)
      CsrMstatus:                rdata = mstatus_rd;
      CsrMisa:                   rdata = MISA_VALUE;
      CsrMie:                    rdata = mie_q;
      CsrMtvec:                  rdata = mtvec_q;
      CsrMscratch:               rdata = mscratch_q;
      CsrMepc:                   rdata = mepc_q;
      CsrMcause:                 rdata = mcause_q;
      CsrMtval:                  rdata = mtval_q;
      CsrMip:                    rdata = '0;
      CsrMcycle, CsrCycle:       rdata = mcycle[31:0];
      CsrMinstret, CsrInstret:   rdata = minstret[31:0];
      CsrMcycleh, CsrCycleh:     rdata = mcycle[63:32];
      CsrMinstreth, CsrInstreth: rdata = minstret[63:32];
      CsrMhartid:                rdata = 32'(HART_ID);
      default:                   known = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_q;
    case (f3)
      F3Rw, F3Rwi: new_val = src;
      F3Rs, F3Rsi: new_val = old_q | src;
      F3Rc, F3Rci: new_val = old_q & ~src;
      default:     new_val = old_q;
    endcase
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (commit && csr_addr == CsrMcycle),
    .wr_hi (commit && csr_addr == CsrMcycleh),
    .wdata (new_val),
    .q     (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (instret_inc),
    .wr_lo (commit && csr_addr == CsrMinstret),
    .wr_hi (commit && csr_addr == CsrMinstreth),
    .wdata (new_val),
    .q     (minstret)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rs1_q   <= '0;
      pc_q    <= '0;
      old_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      wen_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      rd_we   <= 1'b0;
      trap    <= 1'b0;
      trap_pc <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            instr_q <= instr;
            rs1_q   <= rs1_data;
            pc_q    <= pc;
            busy    <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          old_q   <= rdata;
          wen_q   <= wr_attempt && !take_trap;
          cause_q <= is_ecall ? CauseEcall : (is_ebreak ? CauseBreak : CauseIllegal);
          tval_q  <= is_ecall ? 32'd0 : (is_ebreak ? pc_q : instr_q);
          done    <= 1'b1;
          trap    <= take_trap;
          rd_we   <= !take_trap && (rd_sel != 5'd0);
          rd_data <= take_trap ? 32'd0 : rdata;
          trap_pc <= take_trap ? {mtvec_q[31:2], 2'b00} : 32'd0;
          state_q <= WRITE;
        end
        WRITE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          rd_we   <= 1'b0;
          trap    <= 1'b0;
          trap_pc <= '0;
          rd_data <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (state_q == WRITE) begin
      if (trap) begin
        mepc_q     <= {pc_q[31:2], 2'b00};
        mcause_q   <= cause_q;
        mtval_q    <= tval_q;
        mpie_bit_q <= mie_bit_q;
        mie_bit_q  <= 1'b0;
      end else if (wen_q) begin
        case (csr_addr)
          CsrMstatus: begin
            mie_bit_q  <= mstatus_wr[3];
            mpie_bit_q <= mstatus_wr[7];
          end
          CsrMie:      mie_q      <= new_val & MieWmask;
          CsrMtvec:    mtvec_q    <= {new_val[31:2], 2'b00};
          CsrMscratch: mscratch_q <= new_val;
          CsrMepc:     mepc_q     <= {new_val[31:2], 2'b00};
          CsrMcause:   mcause_q   <= new_val;
          CsrMtval:    mtval_q    <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule
